// File: rtl/sum_differentiator.sv
// -----------------------------------------------------------------------------
// sum_differentiator
//
// Recovers the increments from a stream of accumulated sums:
//   data_out[n] = sum_in[n] - sum_in[n-1]   (mod 2^WIDTH)
// Single registered stage with valid/ready handshakes on both sides, a
// PRIME/RUN priming state machine and a delivered-sample counter.
//
// Optional feature (compile-time macro SUM_DIFF_BORROW_EN):
//   adds borrow_out, set when the subtraction wrapped (sum_in < reference).
//
// Parameters:
//   WIDTH      data and sum width
//   CNT_WIDTH  width of sample_cnt
//   PRIME_MODE 0: reference starts at 0, the first sample is output as is
//              1: the first sample only loads the reference
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   sum_in       accumulated sum sample      (with sum_valid / sum_ready)
//   resync       synchronous restart of the difference chain
//   data_out     recovered increment         (with data_valid / data_ready)
//   first_out    data_out is the first output since reset or resync
//   sample_cnt   number of outputs transferred (wraps)
//   borrow_out   subtraction borrowed (only with SUM_DIFF_BORROW_EN)
// -----------------------------------------------------------------------------
module sum_differentiator #(
  parameter int WIDTH      = 4,
  parameter int CNT_WIDTH  = 8,
  parameter int PRIME_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     sum_in,
  input  logic                 sum_valid,
  output logic                 sum_ready,
  input  logic                 resync,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 first_out,
  output logic [CNT_WIDTH-1:0] sample_cnt
`ifdef SUM_DIFF_BORROW_EN
  ,
  output logic                 borrow_out
`endif
);

  typedef enum logic {PRIME, RUN} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 first_q, first_d;
  // Set by a PRIME_MODE=1 prime so the next real output is flagged first.
  logic                 pend_first_q, pend_first_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef SUM_DIFF_BORROW_EN
  logic                 borrow_q, borrow_d;
`endif

  logic acc;
  logic xfer;

  // No skid buffer: accept only when the output register is free or draining.
  assign sum_ready = (~valid_q | data_ready) & ~resync;
  assign acc       = sum_valid & sum_ready;
  assign xfer      = valid_q & data_ready;

  always_comb begin
    // NOTE: every _d starts as its _q (hold), so no path can leave a
    // combinational output unassigned and infer a latch.
    state_d      = state_q;
    prev_d       = prev_q;
    data_d       = data_q;
    valid_d      = valid_q;
    first_d      = first_q;
    pend_first_d = pend_first_q;
    cnt_d        = cnt_q;
`ifdef SUM_DIFF_BORROW_EN
    borrow_d     = borrow_q;
`endif

    if (xfer) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    if (resync) begin
      // Restart the chain; any undelivered output is discarded.
      state_d      = PRIME;
      prev_d       = '0;
      valid_d      = 1'b0;
      pend_first_d = 1'b0;
`ifdef SUM_DIFF_BORROW_EN
      borrow_d     = 1'b0;
`endif
    end else begin
      if (xfer) begin
        valid_d = 1'b0;
      end
      if (acc) begin
        unique case (state_q)
          PRIME: begin
            prev_d  = sum_in;
            state_d = RUN;
            if (PRIME_MODE != 0) begin
              // Reference load only; valid is left to the xfer logic above.
              pend_first_d = 1'b1;
            end else begin
              data_d   = sum_in;
              valid_d  = 1'b1;
              first_d  = 1'b1;
`ifdef SUM_DIFF_BORROW_EN
              borrow_d = 1'b0;
`endif
            end
          end
          RUN: begin
            // Wrap-around difference: truncation to WIDTH is intentional.
            data_d       = sum_in - prev_q;
            prev_d       = sum_in;
            valid_d      = 1'b1;
            first_d      = pend_first_q;
            pend_first_d = 1'b0;
`ifdef SUM_DIFF_BORROW_EN
            borrow_d     = (sum_in < prev_q);
`endif
          end
          default: begin
            state_d = PRIME;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, and the
  // reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PRIME;
      prev_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      first_q      <= 1'b0;
      pend_first_q <= 1'b0;
      cnt_q        <= '0;
`ifdef SUM_DIFF_BORROW_EN
      borrow_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      first_q      <= first_d;
      pend_first_q <= pend_first_d;
      cnt_q        <= cnt_d;
`ifdef SUM_DIFF_BORROW_EN
      borrow_q     <= borrow_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign first_out  = first_q;
  assign sample_cnt = cnt_q;
`ifdef SUM_DIFF_BORROW_EN
  assign borrow_out = borrow_q;
`endif

endmodule

// File: doc/sum_differentiator.md
Name: sum_differentiator

Overview:
Inverse of the team's 4-bit running-sum accumulator. Takes a stream of accumulated sums and recovers the original increments: data_out[n] = sum_in[n] - sum_in[n-1], modulo 2^WIDTH. The block sits on the consumer side of an accumulator output, or in the bench as a reference decoder. It is a single-stage registered pipeline with valid/ready handshakes on both sides, a priming state machine and a delivered-sample counter.

Parameters:
WIDTH, 4, data and sum width in bits
CNT_WIDTH, 8, width of sample_cnt
PRIME_MODE, 0, 0 = reference preset to 0, so the first sample outputs sum_in; 1 = the first sample only loads the reference and produces no output

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
sum_in  input  WIDTH  accumulated sum sample
sum_valid  input  1  sum_in valid
sum_ready  output  1  block can accept sum_in
resync  input  1  synchronous restart of the difference chain
data_out  output  WIDTH  recovered increment
data_valid  output  1  data_out valid
data_ready  input  1  downstream accepts data_out
first_out  output  1  data_out is the first output since reset or resync
sample_cnt  output  CNT_WIDTH  count of outputs transferred

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk and rst, sampled on the rising edge of clk.
- Reset values:
  - data_out = 0, data_valid = 0, first_out = 0, sample_cnt = 0
  - internal reference prev = 0
  - state = PRIME
  - sum_ready = 1 in the first cycle after reset.
- Handshakes:
  - Input accept: acc = sum_valid & sum_ready.
  - Output transfer: xfer = data_valid & data_ready.
  - sum_ready = (~data_valid | data_ready) & ~resync. This is combinational, with no skid buffer.
  - Latency: 1 cycle from an accepted sum to data_valid.
- Output hold: while data_valid=1 and data_ready=0, data_out and first_out hold stable and no new sum is accepted.
- State machine (states PRIME, RUN):
  - PRIME, acc, PRIME_MODE=0: data_out <= sum_in - 0; data_valid <= 1; first_out <= 1; prev <= sum_in; go to RUN.
  - PRIME, acc, PRIME_MODE=1: prev <= sum_in; data_valid unchanged by this accept (cleared by xfer as usual); next output gets first_out=1; go to RUN.
  - RUN, acc: data_out <= sum_in - prev, truncated to WIDTH bits (wrap-around, no saturation); prev <= sum_in; data_valid <= 1; first_out <= 0, except it is 1 for the first output after a PRIME_MODE=1 prime.
  - xfer without acc in the same cycle: data_valid <= 0.
  - xfer and acc in the same cycle: new data is loaded and data_valid stays 1.
- sample_cnt increments by 1 on every xfer and wraps from 2^CNT_WIDTH-1 to 0.
- resync=1 (synchronous, any state):
  - prev <= 0; state <= PRIME; data_valid <= 0, so a pending undelivered output is discarded.
  - sum_ready = 0 that cycle.
  - sample_cnt is not cleared.
  - If rst and resync are both high, rst wins.
- Reset mid-transfer: all state returns to reset values on the next edge and pending data is dropped.
- Arithmetic: unsigned modulo 2^WIDTH. A decreasing sum yields the two's-complement wrapped difference.

Optional Feature:
Macro SUM_DIFF_BORROW_EN.
- Defined: adds output port borrow_out (1 bit).
  - Registered alongside data_out.
  - 1 when sum_in < prev (unsigned) at accept, i.e. the subtraction borrowed, indicating accumulator wrap.
  - Reset value 0. Cleared by resync. Held with data_out under backpressure.
  - In PRIME with PRIME_MODE=0, always 0.
- Undefined: borrow_out port and its logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=4, PRIME_MODE=0, data_ready=1; sums 3,5,12,2 on consecutive cycles -> data_out 3,2,7,6 one cycle later each; first_out 1,0,0,0; borrow_out 0,0,0,1; sample_cnt reaches 4.
2. PRIME_MODE=1; sums 3,5,9 -> outputs 2,4 only; first_out=1 on the 2; sample_cnt=2.
3. Backpressure: data_ready=0 for 3 cycles after an output of 7 -> data_out stays 7, data_valid=1, sum_ready=0 for all 3 cycles; the next sum (13 after 12) is accepted only after release -> output 1.
4. resync mid-stream, with sums 4,6 then resync while output 2 is pending, then sum 9 -> the pending 2 is dropped; next output is 9 with first_out=1; sample_cnt unchanged by resync.
5. rst asserted for 1 cycle while data_valid=1 -> next cycle data_valid=0, data_out=0, sample_cnt=0, state PRIME; sum 5 -> output 5.
6. CNT_WIDTH=2; 5 transfers -> sample_cnt sequence 1,2,3,0,1; simultaneous xfer and acc every cycle keeps data_valid=1 continuously.
